// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg: immediate format codes and width helpers shared by the immediate pipeline.
package riscv_imm_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    function automatic int shamt_w(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction
endpackage

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: instruction-in / immediate-out handshake bundle.
interface imm_ext_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       inmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  inmExt;
    logic             imm_illegal;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, inst, inmSrc, in_tag, out_ready,
        input  in_ready, out_valid, inmExt, imm_illegal, out_tag
    );
    modport slave (
        input  in_valid, inst, inmSrc, in_tag, out_ready,
        output in_ready, out_valid, inmExt, imm_illegal, out_tag
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I/RV64I immediate extraction and sign extension.
module imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      inm_src,
    output logic [XLEN-1:0] inm_ext,
    output logic            illegal
);
    localparam int SW = shamt_w(XLEN);
    logic [31:0] i32;
    logic        unused_opcode;
    assign unused_opcode = ^inst[6:0];
    assign i32 = inm_src == IMM_I     ? {{20{inst[31]}}, inst[31:20]}
               : inm_src == IMM_S     ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
               : inm_src == IMM_B     ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
               : inm_src == IMM_J     ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
               : inm_src == IMM_U     ? {inst[31:12], 12'b0}
               : inm_src == IMM_SHAMT ? 32'(inst[20 +: SW])
               : '0;
    // shamt has bit 31 clear, so one signed widening covers every format
    assign inm_ext = XLEN'($signed(i32));
    assign illegal = inm_src > IMM_SHAMT;
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: decodes immediates at push time into a 2-entry FIFO with tag sideband and flush.
module imm_ext_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    imm_ext_pipe_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;
    ent_t            head_q, head_d, tail_q, tail_d, new_e;
    logic [1:0]      count_q, count_d;
    logic            push, pop, dec_ill;
    logic [XLEN-1:0] dec_imm;
    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (bus.inst),
        .inm_src (bus.inmSrc),
        .inm_ext (dec_imm),
        .illegal (dec_ill)
    );
    assign new_e           = '{imm: dec_imm, ill: dec_ill, tag: bus.in_tag};
    assign bus.in_ready    = !reset && count_q != 2'd2;
    assign bus.out_valid   = count_q != 2'd0;
    assign bus.inmExt      = head_q.imm;
    assign bus.imm_illegal = head_q.ill;
    assign bus.out_tag     = head_q.tag;
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;
    // head is the output register; tail only fills when head is occupied and not leaving
    always_comb begin
        count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
        head_d  = (push && (count_q == 2'd0 || (pop && count_q == 2'd1))) ? new_e
                : (pop && count_q == 2'd2) ? tail_q
                : head_q;
        tail_d  = (push && !pop && count_q == 2'd1) ? new_e : tail_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed checks of imm_ext_pipe at XLEN=32 and XLEN=64.
module tb_imm_ext_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int fails = 0;
    logic [31:0] q[$];

    imm_ext_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_ext_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    imm_ext_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
    imm_ext_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .reset(reset), .flush(flush), .bus(b64));

    always #5 clk = ~clk;

    assign b64.in_valid  = b32.in_valid;
    assign b64.inst      = b32.inst;
    assign b64.inmSrc    = b32.inmSrc;
    assign b64.in_tag    = b32.in_tag;
    assign b64.out_ready = b32.out_ready;

    always @(posedge clk)
        if (!reset && !flush && b32.out_valid && b32.out_ready) q.push_back(b32.out_tag);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 10;
    logic [31:0] v_inst [NV] = '{32'hFFF00093, 32'hFE112C23, 32'hFE000EE3, 32'h0080006F, 32'h123452B7,
                                 32'h800002B7, 32'h01F09093, 32'h02009093, 32'hFFFFFFFF, 32'h7FF00093};
    logic [2:0]  v_src  [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd0};
    logic [31:0] v_e32  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000008, 32'h12345000,
                                 32'h80000000, 32'h0000001F, 32'h00000000, 32'h00000000, 32'h000007FF};
    logic [63:0] v_e64  [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                                 64'h8, 64'h12345000, 64'hFFFFFFFF80000000, 64'h1F, 64'h20, 64'h0, 64'h7FF};
    logic        v_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || b32.inmExt !== 32'd0 || b32.imm_illegal !== 1'b0 || b32.out_tag !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b imm=%h ill=%b tag=%h want all zero",
                     b32.out_valid, b32.inmExt, b32.imm_illegal, b32.out_tag);
        end
        checks++;
        if (b32.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 0", b32.in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (b32.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_in_ready: got %b want 1", b32.in_ready);
        end
    endtask

    task automatic test_formats();
        b32.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            b32.in_valid = 1'b1;
            b32.inst     = v_inst[i];
            b32.inmSrc   = v_src[i];
            b32.in_tag   = 32'(i);
            step();
            b32.in_valid = 1'b0;
            checks++;
            if (b32.out_valid !== 1'b1 || b32.inmExt !== v_e32[i] || b32.imm_illegal !== v_ill[i]) begin
                fails++;
                $display("FAIL fmt32[%0d]: got v=%b imm=%h ill=%b want v=1 imm=%h ill=%b",
                         i, b32.out_valid, b32.inmExt, b32.imm_illegal, v_e32[i], v_ill[i]);
            end
            checks++;
            if (b64.inmExt !== v_e64[i] || b64.imm_illegal !== v_ill[i]) begin
                fails++;
                $display("FAIL fmt64[%0d]: got imm=%h ill=%b want imm=%h ill=%b",
                         i, b64.inmExt, b64.imm_illegal, v_e64[i], v_ill[i]);
            end
            step();
        end
        b32.inmSrc = 3'd7;
        b32.inst   = 32'h12345678;
        b32.in_valid = 1'b1;
        step();
        b32.in_valid = 1'b0;
        checks++;
        if (b32.inmExt !== 32'd0 || b32.imm_illegal !== 1'b1) begin
            fails++;
            $display("FAIL fmt_src7: got imm=%h ill=%b want imm=0 ill=1", b32.inmExt, b32.imm_illegal);
        end
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || b32.imm_illegal !== 1'b1) begin
            fails++;
            $display("FAIL fmt_empty_hold: got v=%b ill=%b want v=0 ill=1", b32.out_valid, b32.imm_illegal);
        end
    endtask

    task automatic test_backpressure();
        q.delete();
        b32.inmSrc = 3'd0;
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1;
        b32.in_tag = 32'd1;
        step();
        checks++;
        if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'd1 || b32.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_first: got v=%b tag=%0d rdy=%b want v=1 tag=1 rdy=1",
                     b32.out_valid, b32.out_tag, b32.in_ready);
        end
        b32.in_tag = 32'd2;
        step();
        checks++;
        if (b32.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_full_ready: got %b want 0", b32.in_ready);
        end
        b32.in_tag = 32'd3;
        step();
        checks++;
        if (b32.in_ready !== 1'b0 || b32.out_tag !== 32'd1) begin
            fails++;
            $display("FAIL bp_stall: got rdy=%b tag=%0d want rdy=0 tag=1", b32.in_ready, b32.out_tag);
        end
        b32.out_ready = 1'b1;
        step();
        checks++;
        if (b32.in_ready !== 1'b1 || b32.out_tag !== 32'd2) begin
            fails++;
            $display("FAIL bp_drain1: got rdy=%b tag=%0d want rdy=1 tag=2", b32.in_ready, b32.out_tag);
        end
        step();
        b32.in_valid = 1'b0;
        checks++;
        if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'd3) begin
            fails++;
            $display("FAIL bp_drain2: got v=%b tag=%0d want v=1 tag=3", b32.out_valid, b32.out_tag);
        end
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || b32.out_tag !== 32'd3) begin
            fails++;
            $display("FAIL bp_empty: got v=%b tag=%0d want v=0 tag=3", b32.out_valid, b32.out_tag);
        end
        checks++;
        if (q.size() != 3 || q[0] !== 32'd1 || q[1] !== 32'd2 || q[2] !== 32'd3) begin
            fails++;
            $display("FAIL bp_order: got %0d pops want 1,2,3", q.size());
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1;
        b32.in_tag = 32'd100;
        step();
        for (int k = 1; k <= 10; k++) begin
            b32.in_tag = 32'(100 + k);
            step();
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'(100 + k) || b32.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d]: got v=%b tag=%0d rdy=%b want v=1 tag=%0d rdy=1",
                         k, b32.out_valid, b32.out_tag, b32.in_ready, 100 + k);
            end
        end
        b32.in_valid = 1'b0;
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || q.size() != 11) begin
            fails++;
            $display("FAIL b2b_drain: got v=%b pops=%0d want v=0 pops=11", b32.out_valid, q.size());
        end
        for (int k = 0; k < 11 && k < q.size(); k++) begin
            checks++;
            if (q[k] !== 32'(100 + k)) begin
                fails++;
                $display("FAIL b2b_order[%0d]: got %0d want %0d", k, q[k], 100 + k);
            end
        end
    endtask

    task automatic test_flush();
        q.delete();
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1;
        b32.in_tag = 32'd7;
        step();
        b32.in_tag = 32'd8;
        step();
        b32.in_tag = 32'd9;
        flush = 1'b1;
        step();
        flush = 1'b0;
        b32.in_valid = 1'b0;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.out_tag !== 32'd7) begin
            fails++;
            $display("FAIL flush_state: got v=%b rdy=%b tag=%0d want v=0 rdy=1 tag=7",
                     b32.out_valid, b32.in_ready, b32.out_tag);
        end
        b32.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL flush_no_leak: got v=%b pops=%0d want v=0 pops=0", b32.out_valid, q.size());
        end
    endtask

    task automatic test_reset_mid();
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1;
        b32.inmSrc = 3'd0;
        b32.inst = 32'hFFF00093;
        b32.in_tag = 32'd5;
        step();
        b32.in_tag = 32'd6;
        step();
        reset = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (b32.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ready: got %b want 0", b32.in_ready);
        end
        step();
        checks++;
        if (b32.out_valid !== 1'b0 || b32.inmExt !== 32'd0 || b32.imm_illegal !== 1'b0 || b32.out_tag !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got v=%b imm=%h ill=%b tag=%h want all zero",
                     b32.out_valid, b32.inmExt, b32.imm_illegal, b32.out_tag);
        end
        reset = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0;
        step();
        checks++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_release: got rdy=%b v=%b want rdy=1 v=0", b32.in_ready, b32.out_valid);
        end
    endtask

    initial begin
        b32.in_valid = 1'b0;
        b32.inst = '0;
        b32.inmSrc = '0;
        b32.in_tag = '0;
        b32.out_ready = 1'b0;
        test_reset();
        test_formats();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate generator for the RV32I/RV64I decode stage.
- Covers all base immediate formats (I, S, B, J, U) plus the shift amount, and flags unused format codes.
- Takes instructions through a valid/ready handshake into a 2-entry buffer, passes a tag (PC or ROB id) alongside, and supports a synchronous flush for redirects.
- Sits between the fetch/decode register and the execute-stage operand mux.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; the immediate is sign-extended to XLEN.
TAG_W, 32, width of the sideband tag carried with each instruction; minimum 1.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous; discards all buffered entries and any same-cycle input
in_valid  input  1  inst/inmSrc/in_tag valid
in_ready  output  1  buffer can accept this cycle
inst  input  32  raw instruction word
inmSrc  input  3  immediate format select
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes head this cycle
inmExt  output  XLEN  extended immediate of head entry
imm_illegal  output  1  head entry used an unused format code
out_tag  output  TAG_W  tag of head entry

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (reset).
- Format codes (inmSrc):
  - 000 I: sext(inst[31:20])
  - 001 S: sext({inst[31:25],inst[11:7]})
  - 010 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
  - 011 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
  - 100 U: sext({inst[31:12],12'b0})
  - 101 SHAMT: zero-extended inst[24:20] when XLEN=32; inst[25:20] when XLEN=64
  - 110, 111: inmExt=0, imm_illegal=1
  - imm_illegal=0 for all other codes.
- Extension is computed at push time; the buffer stores {inmExt, imm_illegal, tag}, not the instruction.
- Buffer: 2-entry FIFO, occupancy count 0..2.
  - in_ready = !reset && count!=2. It depends on registered state only, never on out_ready.
  - Push = in_valid && in_ready && !flush.
  - Pop = out_valid && out_ready.
  - out_valid = count!=0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (1 cycle). Sustained throughput is 1 per cycle when out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1; the head advances to the new entry.
  - count=2: no push is possible.
  - count=0: no pop is possible; count becomes 1.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush or reset.
- Output stability: while out_valid && !out_ready, inmExt/imm_illegal/out_tag are held stable. When count=0 they hold the last head value.
- flush: at the next edge count=0 and out_valid=0. It overrides push and pop in the same cycle; output data is unchanged.
- reset: count=0, out_valid=0, inmExt=0, imm_illegal=0, out_tag=0. It has priority over flush and overrides mid-operation (buffered entries are lost). in_ready=0 while reset is high, and 1 the cycle after it deasserts.
- XLEN=64: all sign extensions replicate inst[31] up to bit 63.

Decomposition:
- Package riscv_imm_pkg holds:
  - format constants IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100, IMM_SHAMT=3'b101
  - default XLEN
  - the function or localparam for shamt width.
- One sub-module, imm_decode: purely combinational inst+inmSrc -> {inmExt, imm_illegal}, parametrised by XLEN.
- imm_ext_pipe instantiates imm_decode and holds the FIFO and control.

Test Plan:
- I/S, XLEN=32, out_ready=1:
  - inst 0xFFF00093, inmSrc 000 -> inmExt 0xFFFFFFFF one cycle later.
  - inst 0xFE112C23, inmSrc 001 -> 0xFFFFFFF8.
- B/J, XLEN=32:
  - inst 0xFE000EE3, inmSrc 010 -> 0xFFFFFFFC.
  - inst 0x0080006F, inmSrc 011 -> 0x00000008, imm_illegal=0.
- U/SHAMT/illegal:
  - inst 0x123452B7, inmSrc 100 -> 0x12345000.
  - XLEN=64, inst 0x800002B7, inmSrc 100 -> 0xFFFFFFFF80000000.
  - inst 0x01F09093, inmSrc 101 -> 0x1F.
  - inmSrc 110 -> inmExt 0, imm_illegal 1.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> tags 1,2 accepted, in_ready=0 from the cycle after the second push, tag 3 held off. Then out_ready=1 -> outputs 1,2,3 in order, no duplicates.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, out_valid constant 1, tags stream in order with 1-cycle latency.
- Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the same-cycle input never appears. Reset asserted with count=2 -> all outputs 0 next cycle, in_ready=0 during reset.
